// File: rtl/pifo_dequeue_checker_pkg.sv
// Shared types for the PIFO harness: flow id, priority and counter widths,
// the dequeue checker state enum and the per-flow count type.
package pifo_dequeue_checker_pkg;

  localparam int FLOW_ID_W  = 4;
  localparam int PRIORITY_W = 16;
  localparam int COUNT_W    = 32;

  typedef logic [FLOW_ID_W-1:0]  flow_id_t;
  typedef logic [PRIORITY_W-1:0] priority_t;
  typedef logic [COUNT_W-1:0]    counter_signal_t;
  typedef counter_signal_t       flow_count_t;

  // IDLE: waiting for a receive phase; CHECK: draining and checking order;
  // DONE: phase finished, further dequeues are overflows.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } checker_state_t;

endpackage

// File: rtl/pifo_dequeue_checker_flow_count_table.sv
// Per-flow receive counters: 2**FLOW_ID_WIDTH saturating counters.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear        zero every counter (an increment in the same cycle lands as 1)
//   inc, inc_id  increment the counter of flow inc_id
//   rd_id        read address
//   rd_count     combinational read of the registered counter at rd_id
module pifo_dequeue_checker_flow_count_table #(
  parameter int FLOW_ID_WIDTH = 4,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     inc,
  input  logic [FLOW_ID_WIDTH-1:0] inc_id,
  input  logic [FLOW_ID_WIDTH-1:0] rd_id,
  output logic [COUNT_WIDTH-1:0]   rd_count
);

  localparam int DEPTH = 2 ** FLOW_ID_WIDTH;

  logic [COUNT_WIDTH-1:0] count_q [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) count_q[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (clear) begin
          // A clear and an increment in the same cycle: the packet is the
          // first one of the new phase, so its flow starts at 1.
          count_q[i] <= (inc && inc_id == FLOW_ID_WIDTH'(i)) ? COUNT_WIDTH'(1) : '0;
        end else if (inc && inc_id == FLOW_ID_WIDTH'(i) && count_q[i] != '1) begin
          count_q[i] <= count_q[i] + COUNT_WIDTH'(1);
        end
      end
    end
  end

  assign rd_count = count_q[rd_id];

endmodule

// File: rtl/pifo_dequeue_checker.sv
// Ordering checker downstream of the PIFO traffic receiver. Each dequeue
// strobe carries the PIFO head (flow id, priority); during a receive phase
// priorities must leave in non-decreasing order. Keeps total and per-flow
// counts, sticky order/overflow errors and a pass/fail verdict.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   i__receive_phase      phase enable; a rising edge starts a new phase
//   i__dequeue            one packet per cycle when high
//   i__packet_flow_id     head flow id (valid with i__dequeue)
//   i__packet_priority    head priority (valid with i__dequeue)
//   i__expected_count     packets the phase must drain, latched on phase start
//   i__query_flow_id      flow table read address
//   o__flow_count         count for i__query_flow_id (combinational read)
//   o__num_recvd          packets received this phase
//   o__error_count        ordering + overflow violations this phase
//   o__order_error        sticky priority inversion
//   o__overflow_error     sticky dequeue after completion
//   o__done               phase finished
//   o__pass               done, no errors, received == expected
//   o__dbg_state          current FSM state
module pifo_dequeue_checker
  import pifo_dequeue_checker_pkg::*;
#(
  parameter int FLOW_ID_WIDTH  = 4,
  parameter int PRIORITY_WIDTH = 16,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i__receive_phase,
  input  logic                      i__dequeue,
  input  logic [FLOW_ID_WIDTH-1:0]  i__packet_flow_id,
  input  logic [PRIORITY_WIDTH-1:0] i__packet_priority,
  input  logic [COUNT_WIDTH-1:0]    i__expected_count,
  input  logic [FLOW_ID_WIDTH-1:0]  i__query_flow_id,
  output logic [COUNT_WIDTH-1:0]    o__flow_count,
  output logic [COUNT_WIDTH-1:0]    o__num_recvd,
  output logic [COUNT_WIDTH-1:0]    o__error_count,
  output logic                      o__order_error,
  output logic                      o__overflow_error,
  output logic                      o__done,
  output logic                      o__pass,
  output checker_state_t            o__dbg_state
);

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (v == '1) ? v : v + COUNT_WIDTH'(1);
  endfunction

  checker_state_t            state_q, state_d;
  logic                      phase_q;
  logic [COUNT_WIDTH-1:0]    expected_q, expected_d;
  logic [COUNT_WIDTH-1:0]    num_q, num_d;
  logic [COUNT_WIDTH-1:0]    err_q, err_d;
  logic                      order_q, order_d;
  logic                      ovf_q, ovf_d;
  logic                      first_q, first_d;
  logic [PRIORITY_WIDTH-1:0] last_q, last_d;

  logic start;
  logic counting;

  // A phase starts on a rising edge of i__receive_phase from any state.
  assign start    = i__receive_phase & ~phase_q;
  // Dequeues count in the start cycle and in CHECK/DONE; IDLE ignores them.
  assign counting = i__dequeue & (start | (state_q != IDLE));

  always_comb begin
    state_d    = state_q;
    expected_d = expected_q;
    num_d      = num_q;
    err_d      = err_q;
    order_d    = order_q;
    ovf_d      = ovf_q;
    first_d    = first_q;
    last_d     = last_q;

    if (start) begin
      expected_d = i__expected_count;
      num_d      = '0;
      err_d      = '0;
      order_d    = 1'b0;
      ovf_d      = 1'b0;
      first_d    = 1'b1;
    end

    if (counting) begin
      num_d = sat_inc(num_d);
      if (state_q == DONE && !start) begin
        ovf_d = 1'b1;
        err_d = sat_inc(err_d);
      end else begin
        // First packet of a phase only seeds the reference priority.
        if (first_d) begin
          first_d = 1'b0;
        end else if (i__packet_priority < last_q) begin
          order_d = 1'b1;
          err_d   = sat_inc(err_d);
        end
        last_d = i__packet_priority;
      end
    end

    if (start) begin
      state_d = (counting && num_d >= expected_d) ? DONE : CHECK;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        CHECK:   if (!i__receive_phase || num_d >= expected_d) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // Sampling the phase during reset keeps a phase that is still high from
    // looking like a fresh rising edge once reset releases.
    phase_q <= i__receive_phase;
    if (reset) begin
      state_q    <= IDLE;
      expected_q <= '0;
      num_q      <= '0;
      err_q      <= '0;
      order_q    <= 1'b0;
      ovf_q      <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= '0;
    end else begin
      state_q    <= state_d;
      expected_q <= expected_d;
      num_q      <= num_d;
      err_q      <= err_d;
      order_q    <= order_d;
      ovf_q      <= ovf_d;
      first_q    <= first_d;
      last_q     <= last_d;
    end
  end

  pifo_dequeue_checker_flow_count_table #(
    .FLOW_ID_WIDTH (FLOW_ID_WIDTH),
    .COUNT_WIDTH   (COUNT_WIDTH)
  ) u_flow_count_table (
    .clk      (clk),
    .reset    (reset),
    .clear    (start),
    .inc      (counting),
    .inc_id   (i__packet_flow_id),
    .rd_id    (i__query_flow_id),
    .rd_count (o__flow_count)
  );

  assign o__num_recvd      = num_q;
  assign o__error_count    = err_q;
  assign o__order_error    = order_q;
  assign o__overflow_error = ovf_q;
  assign o__done           = (state_q == DONE);
  assign o__pass           = (state_q == DONE) & ~order_q & ~ovf_q & (num_q == expected_q);
  assign o__dbg_state      = state_q;

endmodule

// File: doc/pifo_dequeue_checker.md
# pifo_dequeue_checker

Testbench-side ordering checker that sits directly downstream of the traffic receiver in the PIFO test harness. Consumes each dequeue strobe together with the PIFO head packet (flow id, priority) and verifies that priorities leave the PIFO in non-decreasing order during a receive phase. Keeps total and per-flow receive counts and produces sticky error and pass/fail status for the bench's end-of-test report.

## Interface
Parameters:
- FLOW_ID_WIDTH, 4: width of flow id; flow table depth is 2**FLOW_ID_WIDTH
- PRIORITY_WIDTH, 16: width of packet priority
- COUNT_WIDTH, 32: width of all counters (matches CounterSignal)

Ports:
- clk  input  1  clock; single clock domain
- reset  input  1  synchronous, active-high
- i__receive_phase  input  1  receive-phase enable, same signal the traffic receiver sees
- i__dequeue  input  1  dequeue strobe from the traffic receiver; one packet per cycle when high
- i__packet_flow_id  input  FLOW_ID_WIDTH  PIFO head flow id, valid when i__dequeue
- i__packet_priority  input  PRIORITY_WIDTH  PIFO head priority, valid when i__dequeue
- i__expected_count  input  COUNT_WIDTH  total packets the phase must drain; sampled on phase start
- i__query_flow_id  input  FLOW_ID_WIDTH  flow table read address
- o__flow_count  output  COUNT_WIDTH  packets received for i__query_flow_id (combinational read)
- o__num_recvd  output  COUNT_WIDTH  packets received this phase
- o__error_count  output  COUNT_WIDTH  ordering + overflow violations this phase
- o__order_error  output  1  sticky: any priority inversion seen
- o__overflow_error  output  1  sticky: dequeue after expected count reached
- o__done  output  1  phase finished
- o__pass  output  1  valid when o__done: no errors and num_recvd == expected

## Operation
- FSM states: IDLE, CHECK, DONE.
- IDLE: waits for i__receive_phase rising edge (high now, low previous cycle). On that edge: clear all counters, sticky flags, flow table, first-packet flag; latch i__expected_count; go CHECK.
- CHECK, on i__dequeue: num_recvd+1; flow table[flow_id]+1; if first packet of phase, load last_priority, no compare; else if i__packet_priority < last_priority, set order_error, error_count+1; always update last_priority to the new value (equal priorities are legal).
- CHECK -> DONE when num_recvd (after update) equals latched expected, or when i__receive_phase falls.
- DONE: o__done=1. Any i__dequeue sets overflow_error, error_count+1; counters still increment. A new i__receive_phase rising edge restarts (clear + CHECK); no pass through IDLE required.
- o__pass = o__done & !order_error & !overflow_error & (num_recvd == expected); 0 outside DONE.
- Counters saturate at all-ones; no wrap.
- Dequeue in IDLE (phase low) is ignored entirely.

## Timing
- All outputs registered except o__flow_count (combinational read of registered table) and o__pass (combinational from registered state).
- Reset values: all counts 0, all flags 0, o__done 0, o__pass 0, state IDLE, flow table all 0.
- Dequeue at cycle t -> o__num_recvd, flow count, error flags reflect it at t+1.
- Completion by count: o__done high at t+1 where t is the cycle of the final expected dequeue.
- Completion by phase drop: o__done high the cycle after i__receive_phase is first seen low.
- expected_count = 0: DONE one cycle after entering CHECK.
- Phase rising edge and dequeue in same cycle: clear takes effect and that dequeue counts as first packet of the new phase.
- reset mid-phase: everything returns to reset values next cycle; a phase still high after reset does not start until a fresh rising edge.

## Structure
- States enum and flow-count type belong in the shared testbench headers package alongside FlowId, Priority, CounterSignal.
- One sub-module: flow_count_table (2**FLOW_ID_WIDTH saturating counters, synchronous clear, one increment port, one combinational read port).

## Test plan
- Expected=5, dequeue priorities 1,3,3,7,9 in consecutive cycles -> num_recvd=5, o__done 1 cycle after 5th dequeue, o__pass=1, error_count=0.
- Expected=4, priorities 2,8,5,9 -> order_error set the cycle after priority 5, error_count=1, o__pass=0 in DONE.
- Expected=3, priorities 4,4,4 then 4th dequeue in DONE -> overflow_error=1, error_count=1, num_recvd=4, o__pass=0.
- Expected=6, flows 0,1,1,3,3,3, receive_phase dropped after 6 -> query flows 0/1/3/2 return 1/2/3/0.
- Expected=10, phase dropped after 4 packets -> o__done next cycle, num_recvd=4, o__pass=0; new rising edge clears counts to 0.
- Reset asserted after 2 of 5 packets with phase held high -> all outputs 0, further dequeues ignored until phase toggles low then high.
